// File: rtl/amp_config_sequencer_if.sv
// Write-request bus between the amplifier config sequencer and the I2C bus master.
// The sequencer presents one register write at a time and waits for an ack/nack pulse.
interface amp_config_sequencer_if;
    logic       i2c_req_out;
    logic [6:0] i2c_dev_out;
    logic [7:0] i2c_reg_out;
    logic [7:0] i2c_data_out;
    logic       i2c_ack_in;
    logic       i2c_nack_in;

    modport master (
        output i2c_req_out,
        output i2c_dev_out,
        output i2c_reg_out,
        output i2c_data_out,
        input  i2c_ack_in,
        input  i2c_nack_in
    );

    modport slave (
        input  i2c_req_out,
        input  i2c_dev_out,
        input  i2c_reg_out,
        input  i2c_data_out,
        output i2c_ack_in,
        output i2c_nack_in
    );
endinterface

// File: rtl/amp_config_sequencer.sv
// Walks the amplifier config table and writes each entry over I2C, retrying
// failed or timed-out writes a bounded number of times before giving up.
module amp_config_sequencer #(
    parameter int         NUM_REGS    = 8,
    parameter int         TBL_AW      = 4,
    parameter int         MAX_RETRY   = 3,
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [6:0] DEV_ADDR    = 7'h2C
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start_in,
    output logic [TBL_AW-1:0]     tbl_addr_out,
    input  logic [15:0]           tbl_data_in,
    amp_config_sequencer_if.master i2c,
    output logic                  busy_out,
    output logic                  cfg_done_out,
    output logic                  cfg_error_out
);

    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [TBL_AW-1:0] IDX_LAST = TBL_AW'(NUM_REGS - 1);
    localparam logic [RT_W-1:0]   RT_MAX   = RT_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_ISSUE,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic              start_dly_q, start_dly_d;
    logic [TBL_AW-1:0] idx_q, idx_d;
    logic [RT_W-1:0]   retry_q, retry_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        data_q, data_d;
    logic              attempt_fail;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            start_dly_q <= 1'b0;
            idx_q       <= '0;
            retry_q     <= '0;
            wd_q        <= '0;
            reg_q       <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            start_dly_q <= start_dly_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            wd_q        <= wd_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
        end
    end

    // A nack wins over a simultaneous ack; the watchdog expiring counts the same as a nack.
    assign attempt_fail = i2c.i2c_nack_in | (wd_q == WD_LAST);

    always_comb begin
        state_d     = state_q;
        start_dly_d = start_in;
        idx_d       = idx_q;
        retry_d     = retry_q;
        wd_d        = '0;
        reg_d       = reg_q;
        data_d      = data_q;

        case (state_q)
            ST_IDLE: begin
                if (start_in && !start_dly_q) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            ST_FETCH: begin
                state_d = start_in ? ST_LATCH : ST_IDLE;
            end
            ST_LATCH: begin
                reg_d   = tbl_data_in[15:8];
                data_d  = tbl_data_in[7:0];
                state_d = start_in ? ST_ISSUE : ST_IDLE;
            end
            ST_ISSUE: begin
                // An abort only takes effect once the in-flight write has resolved.
                if (attempt_fail) begin
                    if (!start_in) begin
                        state_d = ST_IDLE;
                    end else if (retry_q < RT_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end else if (i2c.i2c_ack_in) begin
                    if (!start_in) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        retry_d = '0;
                        state_d = ST_FETCH;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = start_in ? ST_ISSUE : ST_IDLE;
            end
            ST_DONE, ST_ERROR: begin
                if (!start_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tbl_addr_out     = idx_q;
    assign i2c.i2c_req_out  = (state_q == ST_ISSUE);
    assign i2c.i2c_dev_out  = DEV_ADDR;
    assign i2c.i2c_reg_out  = reg_q;
    assign i2c.i2c_data_out = data_q;
    assign busy_out         = (state_q == ST_FETCH) || (state_q == ST_LATCH) ||
                              (state_q == ST_ISSUE) || (state_q == ST_GAP);
    assign cfg_done_out     = (state_q == ST_DONE);
    assign cfg_error_out    = (state_q == ST_ERROR);

endmodule

// File: tb/tb_amp_config_sequencer.sv
// Directed bench for amp_config_sequencer: a table of retry/timeout scenarios run
// against a small I2C responder model, plus hand-written latency, abort and reset sequences.
module tb_amp_config_sequencer;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        start_in;
    logic [3:0]  tbl_addr_out;
    logic [15:0] tbl_data_in;
    logic        busy_out;
    logic        cfg_done_out;
    logic        cfg_error_out;

    amp_config_sequencer_if bus ();

    amp_config_sequencer #(
        .NUM_REGS    (8),
        .TBL_AW      (4),
        .MAX_RETRY   (3),
        .TIMEOUT_CYC (16),
        .DEV_ADDR    (7'h2C)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .start_in      (start_in),
        .tbl_addr_out  (tbl_addr_out),
        .tbl_data_in   (tbl_data_in),
        .i2c           (bus.master),
        .busy_out      (busy_out),
        .cfg_done_out  (cfg_done_out),
        .cfg_error_out (cfg_error_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom_reg(input int i);
        return 8'h40 + 8'(i);
    endfunction

    function automatic logic [7:0] rom_dat(input int i);
        return 8'hA5 ^ 8'(i * 7);
    endfunction

    // Synchronous table: data for an address appears one cycle after it is presented.
    always_ff @(posedge clk_in) begin
        tbl_data_in <= {rom_reg(int'(tbl_addr_out)), rom_dat(int'(tbl_addr_out))};
    end

    typedef struct {
        string name;
        int    fault_entry;
        int    fault_cnt;
        int    fault_kind;
        int    exp_attempts;
        bit    exp_done;
        bit    exp_err;
        int    exp_min_gap;
        int    exp_last_hi;
        int    exp_max_addr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int attempts, exp_idx, req_cnt, low_len, hi_len, last_hi, min_gap, max_addr;
    int fail_left, fault_entry, fault_kind;
    bit req_prev, pulse_on, auto_resp;

    localparam int RESP_DELAY = 5;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic reset_model();
        attempts    = 0;
        exp_idx     = 0;
        req_cnt     = 0;
        low_len     = 0;
        hi_len      = 0;
        last_hi     = 0;
        min_gap     = 1000;
        max_addr    = 0;
        fail_left   = 0;
        fault_entry = -1;
        fault_kind  = 0;
        req_prev    = 1'b0;
        pulse_on    = 1'b0;
        auto_resp   = 1'b1;
        bus.i2c_ack_in  = 1'b0;
        bus.i2c_nack_in = 1'b0;
    endtask

    // One clock of the responder: sample on the falling edge, then drive the next ack/nack.
    task automatic cycle_step();
        @(negedge clk_in);
        if (bus.i2c_req_out) begin
            if (!req_prev) begin
                attempts++;
                if (attempts > 1 && low_len < min_gap) min_gap = low_len;
                hi_len  = 0;
                req_cnt = 0;
                check_output("attempt_reg", int'(bus.i2c_reg_out), int'(rom_reg(exp_idx)));
                check_output("attempt_data", int'(bus.i2c_data_out), int'(rom_dat(exp_idx)));
            end
            hi_len++;
        end else begin
            if (req_prev) begin
                last_hi = hi_len;
                low_len = 1;
            end else begin
                low_len++;
            end
        end
        if (int'(tbl_addr_out) > max_addr) max_addr = int'(tbl_addr_out);

        if (pulse_on) begin
            bus.i2c_ack_in  = 1'b0;
            bus.i2c_nack_in = 1'b0;
            pulse_on = 1'b0;
        end else if (bus.i2c_req_out && auto_resp) begin
            req_cnt++;
            if (req_cnt == RESP_DELAY) begin
                if (exp_idx == fault_entry && fail_left > 0) begin
                    fail_left--;
                    if (fault_kind == 0) begin
                        bus.i2c_nack_in = 1'b1;
                        pulse_on = 1'b1;
                    end else if (fault_kind == 1) begin
                        bus.i2c_ack_in  = 1'b1;
                        bus.i2c_nack_in = 1'b1;
                        pulse_on = 1'b1;
                    end
                end else begin
                    bus.i2c_ack_in = 1'b1;
                    pulse_on = 1'b1;
                    exp_idx++;
                end
            end
        end
        req_prev = bus.i2c_req_out;
    endtask

    task automatic apply_stimulus(input vec_t v);
        int held_attempts;
        reset_model();
        fault_entry = v.fault_entry;
        fail_left   = v.fault_cnt;
        fault_kind  = v.fault_kind;
        start_in    = 1'b1;
        for (int c = 0; c < 3000 && !(cfg_done_out || cfg_error_out); c++) cycle_step();
        check_output({v.name, "_attempts"}, attempts, v.exp_attempts);
        check_output({v.name, "_done"}, int'(cfg_done_out), int'(v.exp_done));
        check_output({v.name, "_error"}, int'(cfg_error_out), int'(v.exp_err));
        check_output({v.name, "_busy_end"}, int'(busy_out), 0);
        check_output({v.name, "_min_gap"}, min_gap, v.exp_min_gap);
        check_output({v.name, "_last_hi"}, last_hi, v.exp_last_hi);
        check_output({v.name, "_max_addr"}, max_addr, v.exp_max_addr);
        held_attempts = attempts;
        repeat (3) cycle_step();
        check_output({v.name, "_one_per_level"}, attempts, held_attempts);
        check_output({v.name, "_flag_held"}, int'(cfg_done_out | cfg_error_out), 1);
        start_in = 1'b0;
        repeat (2) cycle_step();
        check_output({v.name, "_flags_clear"}, int'(cfg_done_out | cfg_error_out), 0);
        check_output({v.name, "_idle_busy"}, int'(busy_out), 0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"nominal",       -1, 0, 0,  8, 1'b1, 1'b0, 2,  5, 7};
        vecs[1] = '{"retry_e2",       2, 1, 0,  9, 1'b1, 1'b0, 1,  5, 7};
        vecs[2] = '{"exhaust_e0",     0, 4, 0,  4, 1'b0, 1'b1, 1,  5, 0};
        vecs[3] = '{"timeout_e0",     0, 4, 2,  4, 1'b0, 1'b1, 1, 16, 0};
        vecs[4] = '{"acknack_e1",     1, 1, 1,  9, 1'b1, 1'b0, 1,  5, 7};
        vecs[5] = '{"retry_last",     7, 1, 0,  9, 1'b1, 1'b0, 1,  5, 7};
        vecs[6] = '{"max_retry_ok",   3, 3, 0, 11, 1'b1, 1'b0, 1,  5, 7};
        vecs[7] = '{"timeout_once",   5, 1, 2,  9, 1'b1, 1'b0, 1,  5, 7};

        reset    = 1'b0;
        start_in = 1'b0;
        reset_model();
        repeat (3) @(negedge clk_in);
        check_output("rst_req", int'(bus.i2c_req_out), 0);
        check_output("rst_busy", int'(busy_out), 0);
        check_output("rst_done", int'(cfg_done_out), 0);
        check_output("rst_error", int'(cfg_error_out), 0);
        check_output("rst_dev", int'(bus.i2c_dev_out), 'h2C);
        check_output("rst_addr", int'(tbl_addr_out), 0);
        check_output("rst_reg", int'(bus.i2c_reg_out), 0);
        check_output("rst_data", int'(bus.i2c_data_out), 0);
        reset = 1'b1;
        repeat (2) cycle_step();

        // Start-to-request latency, then abort while entry 3 is in flight.
        reset_model();
        start_in = 1'b1;
        cycle_step();
        check_output("fetch_busy", int'(busy_out), 1);
        check_output("fetch_no_req", int'(bus.i2c_req_out), 0);
        cycle_step();
        check_output("latch_no_req", int'(bus.i2c_req_out), 0);
        cycle_step();
        check_output("first_req_latency", int'(bus.i2c_req_out), 1);
        check_output("first_req_dev", int'(bus.i2c_dev_out), 'h2C);
        for (int c = 0; c < 200 && attempts < 4; c++) cycle_step();
        check_output("abort_reach_e3", attempts, 4);
        check_output("abort_addr_e3", int'(tbl_addr_out), 3);
        start_in  = 1'b0;
        auto_resp = 1'b0;
        repeat (8) cycle_step();
        check_output("abort_req_held", int'(bus.i2c_req_out), 1);
        bus.i2c_ack_in = 1'b1;
        pulse_on = 1'b1;
        cycle_step();
        check_output("abort_req_drop", int'(bus.i2c_req_out), 0);
        check_output("abort_idle", int'(busy_out), 0);
        repeat (3) cycle_step();
        check_output("abort_no_flags", int'(cfg_done_out | cfg_error_out), 0);
        check_output("abort_no_new_req", attempts, 4);

        // Dropping start during FETCH returns straight to idle.
        reset_model();
        start_in = 1'b1;
        cycle_step();
        check_output("fetch_abort_busy", int'(busy_out), 1);
        start_in = 1'b0;
        cycle_step();
        check_output("fetch_abort_idle", int'(busy_out), 0);
        cycle_step();
        check_output("fetch_abort_no_req", attempts, 0);

        // The nominal vector runs first, so it also confirms the restart begins at entry 0.
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Reset asserted mid-write, released with start still high.
        reset_model();
        start_in = 1'b1;
        for (int c = 0; c < 20 && attempts < 1; c++) cycle_step();
        check_output("midrst_req_before", int'(bus.i2c_req_out), 1);
        #2;
        reset = 1'b0;
        #1;
        check_output("midrst_req_drop", int'(bus.i2c_req_out), 0);
        check_output("midrst_busy", int'(busy_out), 0);
        reset_model();
        @(negedge clk_in);
        reset = 1'b1;
        cycle_step();
        check_output("midrst_restart_busy", int'(busy_out), 1);
        repeat (2) cycle_step();
        check_output("midrst_restart_req", attempts, 1);
        start_in = 1'b0;
        for (int c = 0; c < 20 && busy_out; c++) cycle_step();
        check_output("midrst_abort_idle", int'(busy_out), 0);
        check_output("midrst_abort_flags", int'(cfg_done_out | cfg_error_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
